// File: rtl/cam_tx_sim.sv
// DVP camera-sensor emulator: drives pclk/vsync/href and RGB565 bytes (high byte
// first) from built-in test patterns or an external frame-memory read port.
module cam_tx_sim #(
    parameter int H_PIXELS    = 160,
    parameter int V_LINES     = 120,
    parameter int VSYNC_LINES = 3,
    parameter int VBP_LINES   = 17,
    parameter int VFP_LINES   = 10,
    parameter int HBLANK      = 144,
    parameter int PCLK_DIV    = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              clk_pll,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [15:0]       pattern_const,
    input  logic [15:0]       pix_data,
    output logic              pclk,
    output logic              vsync,
    output logic              href,
    output logic [7:0]        data_out,
    output logic [ADDR_W-1:0] pix_addr,
    output logic              frame_start,
    output logic              busy,
    output logic [15:0]       frame_count
);

    localparam int L     = 2*H_PIXELS + HBLANK;
    localparam int COL_W = $clog2(L);
    localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;
    localparam int BAR_W = H_PIXELS / 8;

    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;

    state_t           state, state_n;
    logic [COL_W-1:0] col, col_n;
    logic [15:0]      line, line_n;
    logic [DIV_W-1:0] div_cnt;
    logic             fall_tick, last_line, href_n, enter_vsync;
    logic             prefetch_first, prefetch_next;
    logic [1:0]       pat_sel;
    logic [15:0]      pat_const, bar_word;
    logic [7:0]       byte1_hold, byte_n;
    logic [2:0]       bar_idx;

    assign fall_tick = pclk && (div_cnt == DIV_W'(PCLK_DIV - 1));

    // Position of the pclk period that starts on the next fall tick.
    always_comb begin
        state_n   = state;
        col_n     = col;
        line_n    = line;
        last_line = 1'b0;
        case (state)
            VSYNC:   last_line = (line == 16'(VSYNC_LINES - 1));
            VBP:     last_line = (line == 16'(VBP_LINES - 1));
            ACTIVE:  last_line = (line == 16'(V_LINES - 1));
            VFP:     last_line = (line == 16'(VFP_LINES - 1));
            default: last_line = 1'b0;
        endcase
        if (state == IDLE) begin
            if (enable) state_n = VSYNC;
        end else if (col == COL_W'(L - 1)) begin
            col_n = '0;
            if (last_line) begin
                line_n = '0;
                case (state)
                    VSYNC:   state_n = VBP;
                    VBP:     state_n = ACTIVE;
                    ACTIVE:  state_n = VFP;
                    default: state_n = enable ? VSYNC : IDLE;
                endcase
            end else begin
                line_n = line + 16'd1;
            end
        end else begin
            col_n = col + COL_W'(1);
        end
    end

    always_comb begin
        enter_vsync = (state_n == VSYNC) && (state != VSYNC);
        href_n      = (state_n == ACTIVE) && (col_n < COL_W'(2*H_PIXELS));
        bar_idx     = 3'((int'(col_n) / 2) / BAR_W);
        case (bar_idx)
            3'd0:    bar_word = 16'hFFFF;
            3'd1:    bar_word = 16'hFFE0;
            3'd2:    bar_word = 16'h07FF;
            3'd3:    bar_word = 16'h07E0;
            3'd4:    bar_word = 16'hF81F;
            3'd5:    bar_word = 16'hF800;
            3'd6:    bar_word = 16'h001F;
            default: bar_word = 16'h0000;
        endcase
        byte_n = 8'h00;
        if (href_n) begin
            case (pat_sel)
                2'd0:    byte_n = 8'(col_n);
                2'd1:    byte_n = col_n[0] ? bar_word[7:0] : bar_word[15:8];
                2'd2:    byte_n = col_n[0] ? byte1_hold : pix_data[15:8];
                default: byte_n = col_n[0] ? pat_const[7:0] : pat_const[15:8];
            endcase
        end
        // Address goes out one pclk before byte0: odd columns inside the line,
        // and the last blank column of the preceding line for pixel 0.
        prefetch_first = (state_n == VBP) && (line_n == 16'(VBP_LINES - 1)) &&
                         (col_n == COL_W'(L - 1));
        prefetch_next  = (state_n == ACTIVE) &&
                         (((col_n == COL_W'(L - 1)) && (line_n != 16'(V_LINES - 1))) ||
                          (col_n[0] && (col_n < COL_W'(2*H_PIXELS - 1))));
    end

    always_ff @(posedge clk_pll or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            col         <= '0;
            line        <= '0;
            div_cnt     <= '0;
            pclk        <= 1'b0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            data_out    <= 8'h00;
            pix_addr    <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            frame_count <= 16'h0000;
            pat_sel     <= 2'd0;
            pat_const   <= 16'h0000;
            byte1_hold  <= 8'h00;
        end else begin
            frame_start <= 1'b0;
            if (div_cnt == DIV_W'(PCLK_DIV - 1)) begin
                div_cnt <= '0;
                pclk    <= ~pclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_tick) begin
                state    <= state_n;
                col      <= col_n;
                line     <= line_n;
                vsync    <= (state_n == VSYNC);
                href     <= href_n;
                data_out <= byte_n;
                busy     <= (state_n != IDLE);
                if (enter_vsync) begin
                    frame_start <= 1'b1;
                    pat_sel     <= pattern_sel;
                    pat_const   <= pattern_const;
                end
                if ((state == VFP) && (state_n != VFP))
                    frame_count <= frame_count + 16'd1;
                if (href_n && !col_n[0])
                    byte1_hold <= pix_data[7:0];
                if (prefetch_first)
                    pix_addr <= '0;
                else if (prefetch_next)
                    pix_addr <= pix_addr + ADDR_W'(1);
            end
        end
    end

endmodule
